// File: rtl/accel_sort_blk.sv
// Decrypt-and-sort block: assembles IN_W-bit beats into records, XORs each with a keystream
// word, insertion-sorts up to BLK records, then drains the sorted block as IN_W-bit beats.
module accel_sort_blk #(
  parameter int IN_W  = 64,
  parameter int REC_W = 128,
  parameter int KEY_W = 32,
  parameter int BLK   = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  idata,
  input  logic             rdy,
  output logic             pop,
  input  logic [REC_W-1:0] key,
  input  logic             key_rdy,
  output logic             key_pull,
  output logic [IN_W-1:0]  odata,
  output logic             push,
  input  logic             not_full,
  input  logic             descend,
  input  logic             no_compare,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [1:0]       fsm_state
);

  localparam int BEATS = REC_W / IN_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Handshakes: a beat moves on pop (rdy=1), key_pull (key_rdy=1) or push (not_full=1);
  // each strobe is combinational from registered state and is never raised without its partner.
  typedef enum logic [1:0] {ST_ASM = 2'd0, ST_KEY = 2'd1, ST_INS = 2'd2, ST_DRAIN = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    beat_cnt, obeat;
  logic [REC_W-1:0] asm_q, rec_q;
  logic [REC_W-1:0] slot     [BLK];
  logic [REC_W-1:0] slot_ins [BLK];
  logic [REC_W-1:0] slot_dn  [BLK];
  logic [CNT_W-1:0] cnt_q, ins_pos;
  logic [REC_W-1:0] out_sh;
  logic             beat_last, obeat_last, flush_go;

  assign beat_last  = (beat_cnt == BW'(BEATS - 1));
  assign obeat_last = (obeat == BW'(BEATS - 1));
  // flush only starts a drain on a record boundary with something held
  assign flush_go   = (state == ST_ASM) && (beat_cnt == '0) && (cnt_q != '0) && flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ASM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ASM:   if (flush_go) state_nxt = ST_DRAIN;
                else if (pop && beat_last) state_nxt = ST_KEY;
      ST_KEY:   if (key_rdy) state_nxt = ST_INS;
      ST_INS:   if ((cnt_q + CNT_W'(1) == CNT_W'(BLK)) || flush) state_nxt = ST_DRAIN;
                else state_nxt = ST_ASM;
      ST_DRAIN: if (push && obeat_last && (cnt_q == CNT_W'(1))) state_nxt = ST_ASM;
      default:  state_nxt = ST_ASM;
    endcase
  end

  always_comb begin
    out_sh   = slot[0] << (int'(obeat) * IN_W);
    pop      = (state == ST_ASM) && rdy && !flush_go;
    key_pull = (state == ST_KEY) && key_rdy;
    push     = (state == ST_DRAIN) && not_full;
    odata    = (state == ST_DRAIN) ? out_sh[REC_W-1 -: IN_W] : '0;
    busy     = (cnt_q != '0) || (state != ST_ASM) || (beat_cnt != '0);
    blk_cnt  = cnt_q;
    fsm_state = state;
  end

  // Position = count of held entries that precede or tie the new record (stable on ties).
  always_comb begin
    ins_pos = cnt_q;
    if (!no_compare) begin
      ins_pos = '0;
      for (int i = 0; i < BLK; i++) begin
        if (CNT_W'(i) < cnt_q) begin
          if (descend ? (slot[i][REC_W-1 -: KEY_W] >= rec_q[REC_W-1 -: KEY_W])
                      : (slot[i][REC_W-1 -: KEY_W] <= rec_q[REC_W-1 -: KEY_W]))
            ins_pos = ins_pos + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < BLK; i++) begin
      if (CNT_W'(i) < ins_pos)       slot_ins[i] = slot[i];
      else if (CNT_W'(i) == ins_pos) slot_ins[i] = rec_q;
      else                           slot_ins[i] = slot[(i > 0) ? i - 1 : 0];
      slot_dn[i] = (i < BLK - 1) ? slot[(i < BLK - 1) ? i + 1 : i] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      obeat    <= '0;
      asm_q    <= '0;
      rec_q    <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < BLK; i++) slot[i] <= '0;
    end else begin
      case (state)
        ST_ASM: if (pop) begin
          asm_q    <= (asm_q << IN_W) | REC_W'(idata);
          beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
        end
        ST_KEY: if (key_rdy) rec_q <= asm_q ^ key;
        ST_INS: begin
          slot  <= slot_ins;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_DRAIN: if (push) begin
          if (obeat_last) begin
            obeat <= '0;
            slot  <= slot_dn;
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            obeat <= obeat + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_sort_blk.sv
// Bench for accel_sort_blk: directed scenarios plus randomized blocks, checked against a
// stable-selection-sort reference model feeding an expected-beat queue.
module tb_accel_sort_blk;
  localparam int IN_W = 64, REC_W = 128, KEY_W = 32, BLK = 4, CNT_W = 3, BEATS = 2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic clk, reset, rdy, pop, key_rdy, key_pull, push, not_full, descend, no_compare, flush, busy;
  logic [IN_W-1:0]  idata, odata;
  logic [REC_W-1:0] key;
  logic [CNT_W-1:0] blk_cnt;
  logic [1:0]       fsm_state;

  int checks = 0, errors = 0, push_cnt = 0;
  logic [IN_W-1:0]  exp_q[$];
  logic [REC_W-1:0] arr_q[$];
  logic             prev_stall = 1'b0, nf_rand = 1'b0;
  logic [IN_W-1:0]  prev_od = '0;

  accel_sort_blk #(.IN_W(IN_W), .REC_W(REC_W), .KEY_W(KEY_W), .BLK(BLK), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .idata(idata), .rdy(rdy), .pop(pop), .key(key), .key_rdy(key_rdy),
    .key_pull(key_pull), .odata(odata), .push(push), .not_full(not_full), .descend(descend),
    .no_compare(no_compare), .flush(flush), .busy(busy), .blk_cnt(blk_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / protocol monitor
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("odata_hold", REC_W'(odata), REC_W'(prev_od));
      if (pop) check("pop_needs_rdy", REC_W'(rdy), 1);
      if (push) begin
        check("push_needs_nf", REC_W'(not_full), 1);
        if (exp_q.size() == 0) check("extra_push", 1, 0);
        else begin
          logic [IN_W-1:0] e;
          e = exp_q.pop_front();
          check("beat", REC_W'(odata), REC_W'(e));
        end
        push_cnt++;
      end
      prev_stall = (fsm_state == ST_DRAIN) && !not_full;
      prev_od    = odata;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (nf_rand) not_full = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // reference model: arrival list, stable selection by key at drain time
  task automatic model_insert(input logic [REC_W-1:0] ct);
    arr_q.push_back(ct ^ key);
  endtask

  task automatic model_drain();
    logic [REC_W-1:0] tmp[$];
    logic [REC_W-1:0] r;
    tmp = arr_q;
    arr_q.delete();
    while (tmp.size() > 0) begin
      int b = 0;
      if (!no_compare)
        for (int i = 1; i < tmp.size(); i++)
          if (descend ? (tmp[i][REC_W-1 -: KEY_W] > tmp[b][REC_W-1 -: KEY_W])
                      : (tmp[i][REC_W-1 -: KEY_W] < tmp[b][REC_W-1 -: KEY_W])) b = i;
      r = tmp[b];
      tmp.delete(b);
      for (int j = 0; j < BEATS; j++) exp_q.push_back(r[REC_W-1-j*IN_W -: IN_W]);
    end
  endtask

  // drivers
  task automatic send_beat(input logic [IN_W-1:0] b);
    int n = 0;
    rdy = 1'b1;
    idata = b;
    @(negedge clk);
    while (!pop && n < 1000) begin @(negedge clk); n++; end
    if (!pop) check("pop_timeout", 0, 1);
    @(posedge clk); #1;
    rdy = 1'b0;
  endtask

  task automatic send_record(input logic [REC_W-1:0] ct);
    send_beat(ct[REC_W-1 -: IN_W]);
    send_beat(ct[IN_W-1:0]);
    model_insert(ct);
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic [KEY_W-1:0] k, input logic [95:0] tail);
    return {k, tail};
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin @(posedge clk); #1; n++; end
    check({tag, "_idle"}, REC_W'(!busy && exp_q.size() == 0), 1);
    check({tag, "_blk_cnt"}, REC_W'(blk_cnt), 0);
  endtask

  initial begin
    int n, start;
    logic [3:0] pat;
    reset = 1'b0; rdy = 1'b0; idata = '0; key = '0; key_rdy = 1'b1; not_full = 1'b1;
    descend = 1'b0; no_compare = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pop", REC_W'(pop), 0);
    check("rst_push", REC_W'(push), 0);
    check("rst_key_pull", REC_W'(key_pull), 0);
    check("rst_odata", REC_W'(odata), 0);
    check("rst_busy", REC_W'(busy), 0);
    check("rst_blk_cnt", REC_W'(blk_cnt), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ascending sort with latency check
    send_record(mk_rec(5, 96'hA0));
    send_record(mk_rec(3, 96'hA1));
    send_record(mk_rec(9, 96'hA2));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("asc_blk_cnt3", REC_W'(blk_cnt), 3);
    send_record(mk_rec(1, 96'hA3));
    model_drain();
    n = 0;
    do begin @(negedge clk); n++; end while (!push && n < 10);
    check("latency", n, 3);
    wait_idle("asc");

    // decrypt + descending + partial flush
    key = {32'h0000000F, 96'h0};
    descend = 1'b1;
    send_record(mk_rec(32'h0A, 96'hB0));
    send_record(mk_rec(32'h00, 96'hB1));
    send_record(mk_rec(32'h0F, 96'hB2));
    flush = 1'b1;
    model_drain();
    wait_idle("dec_desc");
    flush = 1'b0; descend = 1'b0; key = '0;

    // stability on equal keys
    send_record(mk_rec(7, 96'hA));
    send_record(mk_rec(7, 96'hB));
    flush = 1'b1;
    model_drain();
    wait_idle("stable");
    flush = 1'b0;

    // arrival-order bypass
    no_compare = 1'b1;
    send_record(mk_rec(9, 96'hC0));
    send_record(mk_rec(1, 96'hC1));
    send_record(mk_rec(5, 96'hC2));
    send_record(mk_rec(3, 96'hC3));
    model_drain();
    wait_idle("bypass");
    no_compare = 1'b0;

    // egress backpressure 1,0,0,1
    for (int i = 0; i < BLK; i++) send_record(mk_rec($urandom_range(0, 15), 96'($urandom)));
    model_drain();
    @(posedge clk); #1;
    @(posedge clk); #1;
    pat = 4'b1001;
    for (int i = 3; i >= 0; i--) begin not_full = pat[i]; @(posedge clk); #1; end
    not_full = 1'b1;
    wait_idle("bp");

    // keystream stall
    key_rdy = 1'b0;
    send_record(mk_rec(4, 96'hD0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("key_stall_pull", REC_W'(key_pull), 0);
      check("key_stall_cnt", REC_W'(blk_cnt), 0);
    end
    @(posedge clk); #1;
    key_rdy = 1'b1;
    flush = 1'b1;
    model_drain();
    wait_idle("key_stall");
    flush = 1'b0;

    // flush raised mid-record, then no pops during the drain
    send_beat(64'h0000_0006_0000_0000);
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_midrec_push", REC_W'(push), 0);
    end
    @(posedge clk); #1;
    send_beat(64'hE0);
    arr_q.push_back({64'h0000_0006_0000_0000, 64'hE0} ^ key);
    model_drain();
    rdy = 1'b1;
    idata = 64'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_no_pop", REC_W'(pop), 0);
    end
    #1;
    rdy = 1'b0;
    flush = 1'b0;
    wait_idle("flush_bnd");

    // reset in the middle of a drain
    for (int i = 0; i < BLK; i++) send_record(mk_rec($urandom_range(0, 15), 96'($urandom)));
    model_drain();
    start = push_cnt;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (push_cnt - start < 3 && n < 100);
    reset = 1'b0;
    #1;
    check("mid_rst_push", REC_W'(push), 0);
    check("mid_rst_blk_cnt", REC_W'(blk_cnt), 0);
    check("mid_rst_busy", REC_W'(busy), 0);
    exp_q.delete();
    arr_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < BLK; i++) send_record(mk_rec($urandom_range(0, 15), 96'($urandom)));
    model_drain();
    wait_idle("post_rst");

    // randomized blocks with random backpressure
    nf_rand = 1'b1;
    for (int b = 0; b < 8; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      descend = 1'($urandom_range(0, 1));
      no_compare = ($urandom_range(0, 3) == 0);
      n = $urandom_range(1, BLK);
      for (int i = 0; i < n; i++)
        send_record({$urandom, $urandom, $urandom, $urandom} & {32'h7, {96{1'b1}}} | {29'($urandom), 99'h0});
      if (n < BLK) flush = 1'b1;
      model_drain();
      wait_idle("rand");
      flush = 1'b0;
    end
    nf_rand = 1'b0;
    @(posedge clk); #1;
    not_full = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/accel_sort_blk.md
Name: accel_sort_blk

Overview:
- Next-generation decrypt-and-sort accelerator.
- Pulls IN_W-bit beats from the PLB read FIFO and assembles REC_W-bit records.
- Decrypts each record by XOR with a keystream word.
- Insertion-sorts up to BLK records into a register array, then drains the sorted block as IN_W-bit beats to the write FIFO.
- Generalises the fixed two-record compare/swap to a parametrised block size, adds a sort-key field, descending mode, a partial-block flush, and a stable order on equal keys.

Parameters:
- IN_W, 64: beat width of the ingress and egress streams.
- REC_W, 128: record width; must be a multiple of IN_W. BEATS = REC_W/IN_W.
- KEY_W, 32: compare field width; the field is rec[REC_W-1 -: KEY_W], compared unsigned.
- BLK, 4: records per sorted block; 2..16.
- CNT_W, 3: counter width; must hold the value BLK.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- idata  in  IN_W  ingress beat.
- rdy  in  1  ingress beat valid.
- pop  out  1  consumes idata this cycle; asserted only while rdy=1.
- key  in  REC_W  keystream word.
- key_rdy  in  1  keystream word valid.
- key_pull  out  1  one-cycle pulse that consumes key.
- odata  out  IN_W  egress beat.
- push  out  1  writes odata this cycle; asserted only while not_full=1.
- not_full  in  1  egress FIFO has space.
- descend  in  1  1 = descending order; sampled per insertion.
- no_compare  in  1  1 = keep arrival order (encryption pass); sampled per insertion.
- flush  in  1  level input; drain a partial block.
- busy  out  1  block buffer non-empty or a record is in flight.
- blk_cnt  out  CNT_W  records currently held.

Behaviour:
- Reset (reset=0, asynchronous): state=ASM; beat count, record count and all slots cleared. pop, push and key_pull = 0; odata=0; busy=0; blk_cnt=0.
- pop, push and key_pull are combinational from registered state and the current handshake inputs.
- State ASM:
  - pop = rdy.
  - Each popped beat shifts into the assembly register, first beat most-significant.
  - On the BEATS-th pop, go to KEY.
  - If beat count=0, blk_cnt>0 and flush=1: go to DRAIN with no pop. flush takes priority over rdy in that cycle.
  - flush while beat count>0 is held off until the record completes.
- State KEY:
  - key_pull = key_rdy.
  - When key_rdy=1: rec <= asm ^ key, go to INS.
  - Stall indefinitely while key_rdy=0.
- State INS (exactly 1 cycle): parallel insert of rec into slot[0..blk_cnt-1], which is held sorted.
  - Position p = number of occupied slots s where the ordering test "s precedes rec or s ties rec" holds.
  - Ascending: s.key <= rec.key. Descending: s.key >= rec.key.
  - Ties therefore insert after existing entries (stable).
  - no_compare=1: p = blk_cnt (append).
  - Slots >= p shift up by one; slot[p] <= rec; blk_cnt += 1.
  - Next state: DRAIN if the new blk_cnt = BLK, or if flush=1; otherwise ASM.
- State DRAIN:
  - odata = current beat of slot[0], most-significant beat first.
  - push = not_full.
  - Each push advances the beat index. After BEATS pushes, the slots shift down by one and blk_cnt -= 1.
  - When blk_cnt reaches 0: go to ASM.
  - not_full=0 holds odata and the beat index stable.
  - No pops occur during DRAIN.
- busy = (blk_cnt != 0) or state != ASM or beat count != 0.
- Latency, no stalls: last pop to the first push = 3 cycles (KEY, INS, then DRAIN).
- Throughput: one beat per cycle on each side.

Test Plan:
- Ascending sort: BLK=4, key=0, descend=0, records with key fields 5, 3, 9, 1 -> 8 pushes in key order 1, 3, 5, 9; each record emitted high beat then low beat; blk_cnt returns to 0.
- Decrypt and descending: key=128'h0000000F_..._0, descend=1, encrypted key fields 0x0A, 0x00, 0x0F -> plaintext keys 0x05, 0x0F, 0x00. Then flush=1 before a 4th record -> output 0x0F, 0x05, 0x00.
- Stability and bypass:
  - Two records with key=7 and tails A then B -> output order A, B.
  - no_compare=1 with keys 9, 1, 5, 3 -> output 9, 1, 5, 3.
- Backpressure: toggle not_full 1,0,0,1 during DRAIN -> no beat lost or duplicated, and odata held while not_full=0. Hold key_rdy=0 for 10 cycles -> key_pull=0 for those cycles and no state advance.
- Flush boundary: flush=1 with beat count=1 -> no drain until that record completes and is inserted. Then drain 1 record; pop stays 0 during DRAIN even while rdy=1.
- Reset mid-drain: assert reset=0 after 3 of 8 pushes -> push=0 and blk_cnt=0 immediately. After release, a fresh block sorts correctly.
